// File: rtl/led_pkg.sv
// led_pkg
// Shared definitions for the LED pattern engine:
//   - display mode encodings (DOT, BAR, BLINK, SCAN)
//   - clog2 helper used to size counters from parameters
//   - gen_pattern: maps (mode, enc, scan_pos, blink_phase) to an LED vector.
//     The result is 32 bits wide; callers truncate it to their LED count.
package led_pkg;

    localparam logic [1:0] MODE_DOT   = 2'd0;
    localparam logic [1:0] MODE_BAR   = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_SCAN  = 2'd3;

    // Smallest r such that 2**r >= value. clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // enc must already be saturated to num_leds by the caller so that a
    // 32-bit compare here never loses information from a wide encoder.
    function automatic logic [31:0] gen_pattern(
        input logic [1:0]  mode,
        input logic [31:0] enc,
        input logic [31:0] scan_pos,
        input logic        blink_phase,
        input logic [31:0] num_leds
    );
        logic [31:0] dot;
        logic [63:0] bar;
        logic [31:0] result;
        dot    = (enc < num_leds) ? (32'd1 << enc) : 32'd0;
        // 64-bit shift so that a full 32-LED bar does not overflow.
        bar    = (64'd1 << ((enc < num_leds) ? enc : num_leds)) - 64'd1;
        result = 32'd0;
        case (mode)
            MODE_DOT:   result = dot;
            MODE_BAR:   result = 32'(bar);
            MODE_BLINK: result = blink_phase ? dot : 32'd0;
            MODE_SCAN:  result = 32'd1 << scan_pos;
            default:    result = 32'd0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/led_pattern_engine_pwm.sv
// led_pwm
// Free-running PWM counter and registered duty gate.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   brightness  - duty level; 0 = never on, all-ones = always on
//   gate        - registered duty gate
module led_pwm #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                gate
);

    logic [PWM_BITS-1:0] cnt;

    // Counter wraps naturally; all-ones brightness overrides the compare so
    // that the top duty level really is 100 % rather than (2**N-1)/2**N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            gate <= 1'b0;
        end else begin
            cnt  <= cnt + PWM_BITS'(1);
            gate <= (cnt < brightness) | (&brightness);
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine
// Drives NUM_LEDS LEDs from an encoder value in one of four display modes,
// re-latching the pattern on a programmable refresh tick and dimming with PWM.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   en           - enable switch; 0 clears the display state
//   enc          - encoder position
//   mode         - display mode (DOT, BAR, BLINK, SCAN)
//   brightness   - PWM duty level
//   leds         - registered LED drive
//   refresh_tick - one-cycle pulse at each refresh boundary
module led_pattern_engine #(
    parameter int NUM_LEDS       = 8,
    parameter int ENC_W          = 5,
    parameter int REFRESH_CYCLES = 200_000,
    parameter int BLINK_TICKS    = 125,
    parameter int PWM_BITS       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [ENC_W-1:0]    enc,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_LEDS-1:0] leds,
    output logic                refresh_tick
);

    import led_pkg::*;

    localparam int RW = clog2(REFRESH_CYCLES);
    localparam int TW = (BLINK_TICKS > 1) ? clog2(BLINK_TICKS) : 1;
    localparam int SW = clog2(NUM_LEDS);
    localparam int NW = clog2(NUM_LEDS + 1);
    localparam int CW = (ENC_W > NW) ? ENC_W : NW;

    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(BLINK_TICKS - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] ENC_SAT   = CW'(NUM_LEDS);

    logic [RW-1:0]       ref_cnt;
    logic [TW-1:0]       tick_cnt;
    logic [SW-1:0]       scan_pos;
    logic                blink_phase;
    logic [NUM_LEDS-1:0] pattern_reg;
    logic [NUM_LEDS-1:0] pattern_next;
    logic [CW-1:0]       enc_wide;
    logic [CW-1:0]       enc_sat;
    logic                at_boundary;
    logic                pwm_gate;

    assign at_boundary = (ref_cnt == REF_LAST);

    // Saturating the encoder at NUM_LEDS keeps DOT empty and BAR full for any
    // out-of-range position, and lets the pattern function work at 32 bits.
    assign enc_wide     = CW'(enc);
    assign enc_sat      = (enc_wide >= ENC_SAT) ? ENC_SAT : enc_wide;
    assign pattern_next = NUM_LEDS'(gen_pattern(mode, 32'(enc_sat), 32'(scan_pos),
                                                blink_phase, 32'(NUM_LEDS)));

    // Refresh counter runs regardless of en, so the refresh timebase stays
    // aligned across enable toggles. refresh_tick rises at the same edge
    // where pattern_reg is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt      <= '0;
            refresh_tick <= 1'b0;
        end else begin
            refresh_tick <= at_boundary;
            ref_cnt      <= at_boundary ? '0 : ref_cnt + RW'(1);
        end
    end

    // Pattern latch and blink/scan timebase. en low takes priority over a
    // simultaneous tick-counter wrap so the display always restarts clean.
    // The pattern is built from the scan_pos/blink_phase values held before
    // this boundary's step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_reg <= '0;
            tick_cnt    <= '0;
            blink_phase <= 1'b0;
            scan_pos    <= '0;
        end else if (!en) begin
            pattern_reg <= '0;
            tick_cnt    <= '0;
            blink_phase <= 1'b0;
            scan_pos    <= '0;
        end else if (at_boundary) begin
            pattern_reg <= pattern_next;
            if (tick_cnt == TICK_LAST) begin
                tick_cnt    <= '0;
                blink_phase <= ~blink_phase;
                scan_pos    <= (scan_pos == SCAN_LAST) ? '0 : scan_pos + SW'(1);
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .brightness (brightness),
        .gate       (pwm_gate)
    );

    // Output stage: pattern masked by the registered PWM gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds <= '0;
        end else if (!en) begin
            leds <= '0;
        end else begin
            leds <= pattern_reg & {NUM_LEDS{pwm_gate}};
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine
// Self-checking bench for led_pattern_engine with a small refresh period.
module tb_led_pattern_engine;

    localparam int N = 8;
    localparam int R = 4;
    localparam int B = 2;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [4:0] enc;
    logic [1:0] mode;
    logic [1:0] brightness;
    logic [7:0] leds;
    logic       refresh_tick;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    // Behavioural model state
    int         m_k;
    int         m_ticks;
    logic [7:0] m_pattern;
    logic [7:0] m_leds;
    logic       m_gate;
    logic       m_tick;

    led_pattern_engine #(
        .NUM_LEDS       (N),
        .ENC_W          (5),
        .REFRESH_CYCLES (R),
        .BLINK_TICKS    (B),
        .PWM_BITS       (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .enc          (enc),
        .mode         (mode),
        .brightness   (brightness),
        .leds         (leds),
        .refresh_tick (refresh_tick)
    );

    always #5 clk = ~clk;

    // Pattern from the display rules: ticks is the number of refresh
    // boundaries seen since the display was last cleared.
    function automatic logic [7:0] model_pattern(input logic [1:0] m, input int e, input int ticks);
        int step;
        logic [7:0] dot;
        logic [7:0] bar;
        step = ticks / B;
        dot  = (e < N) ? 8'(1 << e) : 8'h00;
        bar  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (i < e) bar[i] = 1'b1;
        end
        case (m)
            2'd0:    return dot;
            2'd1:    return bar;
            2'd2:    return (step % 2 == 1) ? dot : 8'h00;
            default: return 8'(1 << (step % N));
        endcase
    endfunction

    // Model advances once per clock edge; k counts edges since reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_ticks = 0; m_pattern = 8'h00;
            m_leds = 8'h00; m_gate = 1'b0; m_tick = 1'b0;
        end else begin
            logic boundary;
            logic new_gate;
            logic [7:0] new_leds;
            boundary = ((m_k % R) == R - 1);
            new_gate = ((m_k % P) < int'(brightness)) || (brightness == 2'd3);
            new_leds = en ? (m_pattern & {8{m_gate}}) : 8'h00;
            if (!en) begin
                m_pattern = 8'h00;
                m_ticks   = 0;
            end else if (boundary) begin
                m_pattern = model_pattern(mode, int'(enc), m_ticks);
                m_ticks++;
            end
            m_tick = boundary;
            m_gate = new_gate;
            m_leds = new_leds;
            m_k++;
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check_output("model_leds", leds, m_leds);
            check_output("model_tick", {7'd0, refresh_tick}, {7'd0, m_tick});
        end
    end

    task automatic apply_stimulus(input logic e, input logic [1:0] m, input logic [4:0] v, input logic [1:0] b);
        en = e; mode = m; enc = v; brightness = b;
    endtask

    // Leaves the bench on the negedge where refresh_tick is high.
    task automatic wait_tick();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * R && !found; i++) begin
            @(negedge clk);
            if (refresh_tick) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL wait_tick: got no tick expected tick within %0d cycles", 3 * R);
        end
    endtask

    initial begin
        int cnt_on;
        int cnt_bad;
        bit found;

        apply_stimulus(1'b1, 2'd0, 5'd3, 2'd3);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 cmp_on = 1'b1;
        repeat (2) @(negedge clk);
        check_output("reset_leds", leds, 8'h00);
        check_output("reset_tick", {7'd0, refresh_tick}, 8'h00);
        rst_n = 1'b1;

        // DOT enc=3: dark through the first tick, then 8'h08.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_output("dot_pre_tick", leds, 8'h00);
            check_output("first_tick", {7'd0, refresh_tick}, (k == 4) ? 8'h01 : 8'h00);
        end
        @(negedge clk);
        check_output("dot_enc3", leds, 8'h08);
        repeat (3) @(negedge clk);
        check_output("dot_enc3_steady", leds, 8'h08);

        // BAR with mid-period encoder changes
        apply_stimulus(1'b1, 2'd1, 5'd0, 2'd3);
        wait_tick(); @(negedge clk);
        check_output("bar_0", leds, 8'h00);
        enc = 5'd5;
        wait_tick(); @(negedge clk);
        check_output("bar_5", leds, 8'h1F);
        enc = 5'd8;
        repeat (2) begin
            @(negedge clk);
            check_output("bar_hold", leds, 8'h1F);
        end
        wait_tick(); @(negedge clk);
        check_output("bar_8", leds, 8'hFF);
        enc = 5'd20;
        wait_tick(); @(negedge clk);
        check_output("bar_20", leds, 8'hFF);

        // BLINK enc=7: 16 of any 32 consecutive cycles show 8'h80
        apply_stimulus(1'b1, 2'd2, 5'd7, 2'd3);
        wait_tick(); @(negedge clk);
        cnt_on = 0; cnt_bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (leds == 8'h80) cnt_on++;
            else if (leds != 8'h00) cnt_bad++;
        end
        check_output("blink_on_count", 8'(cnt_on), 8'd16);
        check_output("blink_bad_count", 8'(cnt_bad), 8'd0);

        // SCAN from a cleared state, encoder toggled randomly
        apply_stimulus(1'b0, 2'd3, 5'd0, 2'd3);
        repeat (2) @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            enc = 5'($urandom_range(0, 31));
            wait_tick(); @(negedge clk);
            check_output("scan_step", leds, 8'(1 << ((i / 2) % 8)));
        end

        // PWM duty on DOT enc=0
        apply_stimulus(1'b1, 2'd0, 5'd0, 2'd3);
        wait_tick(); @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            brightness = 2'(b);
            repeat (3) @(negedge clk);
            cnt_on = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (leds == 8'h01) cnt_on++;
            end
            check_output("pwm_duty", 8'(cnt_on), 8'(4 * b));
        end

        // en low mid-SCAN at scan_pos 5, then re-enable
        apply_stimulus(1'b0, 2'd3, 5'd0, 2'd3);
        repeat (2) @(negedge clk);
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (leds == 8'h20) found = 1'b1;
        end
        check_output("scan_reach_5", {7'd0, found}, 8'h01);
        en = 1'b0;
        @(negedge clk);
        check_output("disable_clear", leds, 8'h00);
        @(negedge clk);
        en = 1'b1;
        wait_tick(); @(negedge clk);
        check_output("scan_restart", leds, 8'h01);

        // Async reset without a clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_leds", leds, 8'h00);
        check_output("async_tick", {7'd0, refresh_tick}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                apply_stimulus(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)),
                               5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            end
        end

        @(negedge clk);
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
Parametrised successor to the board LED pattern driver. Drives NUM_LEDS user LEDs from an encoder value, with four display modes and PWM brightness. The pattern is re-latched on a programmable refresh tick. Sits between the rotary-encoder counter and the board LED pins, gated by a front-panel enable switch.

Parameters:
NUM_LEDS, 8, number of LED outputs (2..32)
ENC_W, 5, encoder value width
REFRESH_CYCLES, 200_000, clk cycles per refresh period (2 ms at 100 MHz); must be >= 2
BLINK_TICKS, 125, refresh ticks per blink half-period / scan step; must be >= 1
PWM_BITS, 4, brightness resolution

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  enable switch; 0 forces all LEDs off
enc  in  ENC_W  encoder position
mode  in  2  display mode (DOT, BAR, BLINK, SCAN)
brightness  in  PWM_BITS  duty level; 0 = off, all-ones = fully on
leds  out  NUM_LEDS  registered LED drive
refresh_tick  out  1  one-cycle pulse at each refresh boundary

Behaviour:
- Reset (rst_n low, async): leds=0, refresh_tick=0, all counters=0, pattern_reg=0, blink_phase=0, scan_pos=0.
- Refresh counter counts 0..REFRESH_CYCLES-1, then wraps to 0. refresh_tick is registered; it is 1 in the cycle after the counter equals REFRESH_CYCLES-1.
- Tick counter counts refresh ticks 0..BLINK_TICKS-1. On wrap, blink_phase toggles and scan_pos advances by 1, wrapping from NUM_LEDS-1 to 0.
- On each refresh_tick, enc and mode are sampled and pattern_reg is loaded. Between ticks, pattern_reg holds.
- DOT: one-hot at bit enc when enc < NUM_LEDS; all zeros otherwise.
- BAR: the low min(enc, NUM_LEDS) bits are set. enc=0 gives all off. enc >= NUM_LEDS gives all on. Compare at width max(ENC_W, clog2(NUM_LEDS+1)), with no truncation.
- BLINK: the DOT pattern while blink_phase=1, zeros while blink_phase=0.
- SCAN: one-hot at scan_pos; enc is ignored.
- PWM: a free-running PWM_BITS counter. Duty gate = (pwm_cnt < brightness), except all-ones brightness, which forces the gate to 1. leds <= pattern_reg & {NUM_LEDS{gate}}, registered, so there is 1 cycle of latency from the gate to the pins.
- Latency from an enc/mode change: visible on leds in the cycle after the next refresh_tick, subject to the PWM gate.
- en=0:
  - Synchronous clear on the next edge: leds=0, pattern_reg=0, blink_phase=0, scan_pos=0, tick counter=0.
  - The refresh counter and refresh_tick keep running.
- en rising: leds stay 0 until the first refresh_tick after en=1.
- mode change mid-period: takes effect only at the next tick. A switch into SCAN starts from the current scan_pos.
- Simultaneous tick-counter wrap and en falling: en wins, and everything clears.

Decomposition:
- Package led_pkg holds:
  - mode encodings: MODE_DOT=2'd0, MODE_BAR=2'd1, MODE_BLINK=2'd2, MODE_SCAN=2'd3
  - a clog2 helper function
  - the pattern-generation function: (mode, enc, scan_pos, blink_phase) -> NUM_LEDS vector
- One sub-module, led_pwm: PWM counter plus duty gate, parametrised by PWM_BITS, output registered.
- The top level holds the refresh/tick counters, pattern_reg and the output AND.

Test Plan:
(Bench params: NUM_LEDS=8, ENC_W=5, REFRESH_CYCLES=4, BLINK_TICKS=2, PWM_BITS=2.)
1. Reset then release, en=1, mode=DOT, enc=3, brightness=3 -> leds=8'h00 until the first refresh_tick (cycle 4), then 8'h08 on the following cycle and steady.
2. mode=BAR with brightness=3, enc=0 / 5 / 8 / 20 -> leds 8'h00 / 8'h1F / 8'hFF / 8'hFF after the next tick; enc changes mid-period are not visible until that tick.
3. mode=BLINK, enc=7 -> leds alternate 8'h00 and 8'h80, each for 8 cycles (2 ticks x 4 cycles).
4. mode=SCAN -> one-hot 8'h01, 8'h02 ... 8'h80, 8'h01, each held for 8 cycles, wrapping correctly; enc changes have no effect.
5. DOT enc=0, brightness=1 -> leds=8'h01 for 1 of every 4 cycles. brightness=2 -> 2 of 4. brightness=0 -> always 0.
6. Assert en=0 mid-SCAN at scan_pos=5 -> leds=0 next cycle. Re-enable -> SCAN resumes from 8'h01 after the first tick. Async rst_n pulse mid-period -> all outputs 0 immediately, without waiting for a clk edge.
